// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions used by the demodulator and the frame synchroniser.
package qpsk_pkg;

  typedef logic [1:0] qpsk_sym_t;

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } sync_state_e;

  localparam int          DEFAULT_SYNC_SYMS = 8;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h1ACF;

  // Completes a payload byte from three earlier symbols plus the current one.
  function automatic logic [7:0] pack_byte(input logic [5:0] acc, input qpsk_sym_t sym);
    return {acc, sym};
  endfunction

endpackage

// File: rtl/qpsk_frame_sync_if.sv
// Symbol input and byte output streams of the QPSK frame synchroniser.
interface qpsk_frame_sync_if;
  import qpsk_pkg::*;

  qpsk_sym_t  sym_in;
  logic       sym_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  // master is the frame synchroniser; slave is the demodulator/byte-sink side
  modport master (
    input  sym_in, sym_valid, byte_ready,
    output byte_out, byte_valid
  );

  modport slave (
    output sym_in, sym_valid, byte_ready,
    input  byte_out, byte_valid
  );

endinterface

// File: rtl/qpsk_frame_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data and one-cycle write-to-read latency.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_wr, do_rd;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A read in the same cycle frees a slot, so a write into a full FIFO still lands.
  always_comb begin
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/qpsk_frame_sync.sv
// Hunts for the sync word in the demodulated QPSK symbol stream, then packs the
// payload symbols into bytes and queues them for the byte sink.
module qpsk_frame_sync
  import qpsk_pkg::*;
#(
  parameter int                       SYNC_SYMS   = 8,
  parameter logic [2*SYNC_SYMS-1:0]   SYNC_WORD   = DEFAULT_SYNC_WORD,
  parameter int                       PAYLOAD_LEN = 4,
  parameter int                       FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  qpsk_frame_sync_if.master           bus,
  output logic                        locked,
  output logic                        frame_start,
  output logic                        frame_end,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int SW = 2 * SYNC_SYMS;
  localparam int BW = $clog2(PAYLOAD_LEN + 1);
  localparam logic [BW-1:0] LAST_BYTE  = BW'(PAYLOAD_LEN - 1);
  localparam logic [0:0]    ST_HUNT    = 1'(HUNT);
  localparam logic [0:0]    ST_PAYLOAD = 1'(PAYLOAD);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sync_sr_q, sync_sr_d;
  logic [1:0]    sym_cnt_q, sym_cnt_d;
  logic [5:0]    acc_q, acc_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic          overflow_q, overflow_d;

  logic          push;
  logic [7:0]    push_data;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;

  assign bus.byte_valid = ~fifo_empty;
  assign bus.byte_out   = fifo_head;
  assign pop            = ~fifo_empty & bus.byte_ready;
  assign locked         = (state_q == ST_PAYLOAD);
  assign overflow       = overflow_q;

  // Only valid symbols advance anything; the final symbol of a frame forces a
  // fresh hunt from a cleared shift register.
  always_comb begin
    state_d     = state_q;
    sync_sr_d   = sync_sr_q;
    sym_cnt_d   = sym_cnt_q;
    acc_d       = acc_q;
    byte_cnt_d  = byte_cnt_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    push        = 1'b0;
    push_data   = '0;
    if (bus.sym_valid && !rst) begin
      if (state_q == ST_HUNT) begin
        sync_sr_d = {sync_sr_q[SW-3:0], bus.sym_in};
        if (sync_sr_d == SYNC_WORD) begin
          state_d     = ST_PAYLOAD;
          frame_start = 1'b1;
        end
      end else begin
        if (sym_cnt_q == 2'd3) begin
          push      = 1'b1;
          push_data = pack_byte(acc_q, bus.sym_in);
          acc_d     = '0;
          sym_cnt_d = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            frame_end  = 1'b1;
            state_d    = ST_HUNT;
            sync_sr_d  = '0;
            byte_cnt_d = '0;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end else begin
          acc_d     = {acc_q[3:0], bus.sym_in};
          sym_cnt_d = sym_cnt_q + 2'd1;
        end
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q | (push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      sync_sr_q  <= '0;
      sym_cnt_q  <= '0;
      acc_q      <= '0;
      byte_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_sr_q  <= sync_sr_d;
      sym_cnt_q  <= sym_cnt_d;
      acc_q      <= acc_d;
      byte_cnt_q <= byte_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule
